bram_stream_reader: RTL and testbench
=====================================

// Module: bram_stream_reader
// PURPOSE
//  Readback counterpart of the DDMTD capture path. The capture logic writes
//  DDMTD sample words into BRAM port B; this block reads a block of words back
//  from a BRAM read port and emits them as an AXI-Stream master, with TLAST on
//  the final word. Used for loopback checking of captured data and for replaying
//  stored patterns. Sits between the BRAM port B and any AXIS consumer in CLK.
// PARAMETERS
//  DATA_WIDTH      256  BRAM word / TDATA width, in bits
//  ADDR_WIDTH      32   BRAM byte-address width
//  BYTES_PER_WORD  DATA_WIDTH/8  address increment per word
//  RD_LATENCY      1    BRAM read latency in cycles; legal values are 1 and 2
//  FIFO_DEPTH      4    output buffer entries; must be >= RD_LATENCY+2, power of 2
// PORTS
//  clk            in   1           single clock for the whole block
//  reset          in   1           asynchronous, active-high reset
//  start          in   1           one-cycle request; sampled only in IDLE
//  abort          in   1           cancels the current transfer
//  base_addr      in   ADDR_WIDTH  byte address of the first word
//  num_words      in   32          number of words to read
//  busy           out  1           high from accepted start until done or abort
//  done           out  1           one-cycle pulse at end of transfer
//  bram_addr      out  ADDR_WIDTH  BRAM byte address
//  bram_en        out  1           BRAM read enable; one read per high cycle
//  bram_dout      in   DATA_WIDTH  BRAM read data, valid RD_LATENCY cycles after en
//  m_axis_tvalid  out  1
//  m_axis_tdata   out  DATA_WIDTH
//  m_axis_tlast   out  1
//  m_axis_tready  in   1
// BEHAVIOUR
//  - Reset values: busy, done, bram_en, m_axis_tvalid, m_axis_tlast = 0;
//    bram_addr, m_axis_tdata = 0. Reset clears the FIFO, the in-flight pipe and
//    all counters. Reset in the middle of a transfer discards it; no done pulse.
//  - States:
//    - IDLE: start=1 latches base_addr and num_words, sets busy, and moves to
//      READ. If num_words==0, go to DONE instead.
//    - READ: issue reads until rd_issued==num_words, then go to DRAIN.
//    - DRAIN: stay until every beat has been accepted, then go to DONE.
//    - DONE: done=1 and busy=0 for one cycle, then IDLE.
//  - start is ignored outside IDLE.
//  - Read issue rule: bram_en=1 in a cycle only when rd_issued<num_words AND
//    fifo_count + inflight < FIFO_DEPTH. Because of this credit check, the FIFO
//    never overflows.
//  - bram_addr = base + rd_issued*BYTES_PER_WORD, computed modulo 2^ADDR_WIDTH;
//    it wraps silently.
//  - In-flight pipe: a RD_LATENCY-deep valid shift register. bram_dout is
//    pushed into the FIFO on the cycle its valid bit emerges from the pipe.
//  - AXIS output:
//    - tvalid = FIFO not empty; tdata = FIFO head.
//    - A beat transfers on tvalid & tready, which pops the FIFO.
//    - tdata and tlast hold stable while tvalid & ~tready.
//    - tlast = 1 exactly on beat index num_words-1.
//  - Latency: first bram_en is the cycle after start is sampled. First tvalid
//    is 2+RD_LATENCY cycles after start is sampled.
//  - Throughput: with tready held high, one beat per cycle, no bubbles.
//  - FIFO full and empty are handled by the credit rule. A push and a pop in
//    the same cycle are both honoured and leave the count unchanged.
//  - done is asserted on the cycle after the final handshake (tlast & tready).
//  - abort (any non-IDLE state):
//    - next cycle: bram_en=0, tvalid=0;
//    - FIFO and pipe flushed; responses still in flight are dropped;
//    - back to IDLE; busy=0; no done pulse.
//  - abort has priority over a simultaneous handshake, and over start.
//  - Counters: rd_issued and beat_cnt are 32 bits, unsigned, and compared
//    against the latched num_words.
// STRUCTURE
//  - Shared package ddmtd_pkg holds: the state enum (IDLE/READ/DRAIN/DONE),
//    the DATA_WIDTH default (256, one third of the 24x32 DDMTD word) and
//    BYTES_PER_WORD.
//  - One sub-module, bram_rd_fifo: synchronous FIFO with push, pop, count,
//    empty and full, and a first-word-fall-through head.
//  - Top level holds the FSM, address generation, credit logic and
//    in-flight pipe.
// TESTING
//  1. base=0x100, num_words=4, tready=1, RD_LATENCY=1:
//     -> addrs 0x100/0x120/0x140/0x160 on consecutive cycles;
//     -> 4 back-to-back beats in BRAM content order, tlast on beat 4;
//     -> done exactly 1 cycle after the last beat.
//  2. num_words=8, tready toggled 1/0 each cycle:
//     -> 8 beats in order, no duplicates or drops;
//     -> tdata stable while stalled; fifo_count never exceeds 4.
//  3. num_words=0:
//     -> no bram_en, no tvalid;
//     -> busy high 1 cycle, done pulse 2 cycles after start.
//  4. num_words=16, abort asserted after beat 5:
//     -> tvalid=0 next cycle, busy=0, no done;
//     -> a new start then yields a clean transfer from beat 0.
//  5. base=0xFFFFFFE0, num_words=2:
//     -> bram_addr 0xFFFFFFE0 then 0x00000000.
//  6. reset pulsed mid-transfer with tready=0:
//     -> all outputs 0 immediately; next start behaves as in test 1.

Source files
------------

// File: rtl/ddmtd_pkg.sv
// Shared types and constants for the DDMTD capture/readback blocks.
package ddmtd_pkg;

  // Readback sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } state_e;

  // One third of the 24x32-bit DDMTD capture word.
  localparam int unsigned DataWidthDefault = 256;

  // Byte-address stride between consecutive BRAM words.
  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

  localparam int unsigned BytesPerWord = bytes_per_word(DataWidthDefault);

endpackage

// File: rtl/bram_rd_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and a flush input.
// The head reads as zero while the FIFO is empty.
module bram_rd_fifo #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  input  logic                     pop_i,
  output logic [DATA_WIDTH-1:0]    data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]         count_q;
  logic                  do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
  assign count_o = count_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage array; no reset needed since the count gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers and occupancy; a flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a block of words from a BRAM read port and replays them as an
// AXI-Stream master with TLAST on the final word. Reads are issued only when
// the output FIFO has room for every response already in flight.
module bram_stream_reader
  import ddmtd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidthDefault,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [31:0]           num_words_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] bram_addr_o,
  output logic                  bram_en_o,
  input  logic [DATA_WIDTH-1:0] bram_dout_i,
  output logic                  m_axis_tvalid_o,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                  m_axis_tlast_o,
  input  logic                  m_axis_tready_i
);

  localparam int unsigned BYTES_PER_WORD = bytes_per_word(DATA_WIDTH);
  localparam int unsigned CntW           = $clog2(FIFO_DEPTH) + 1;

  state_e                state_q;
  logic                  busy_q, done_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           num_q, rd_issued_q, beat_cnt_q;
  logic [RD_LATENCY-1:0] pipe_q;

  logic [CntW-1:0]       fifo_count;
  logic                  fifo_empty, fifo_full;
  logic [CntW:0]         credit_used;
  logic                  rd_en, push, flush, tvalid, last_beat, hs;

  // Read issue, credit and handshake decode.
  always_comb begin
    credit_used = (CntW + 1)'(fifo_count) + (CntW + 1)'($countones(pipe_q));
    rd_en       = (state_q == StRead) && (rd_issued_q < num_q) && !fifo_full &&
                  (credit_used < (CntW + 1)'(FIFO_DEPTH));
    flush       = abort_i && (state_q != StIdle);
    push        = pipe_q[RD_LATENCY-1];
    tvalid      = ~fifo_empty;
    last_beat   = tvalid && (beat_cnt_q == num_q - 32'd1);
    hs          = tvalid && m_axis_tready_i;
  end

  assign bram_en_o       = rd_en;
  assign bram_addr_o     = base_q + ADDR_WIDTH'(rd_issued_q) * ADDR_WIDTH'(BYTES_PER_WORD);
  assign m_axis_tvalid_o = tvalid;
  assign m_axis_tlast_o  = last_beat;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

  // Valid bits of reads in flight; the oldest bit marks bram_dout as usable.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pipe_q <= '0;
    end else if (flush) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= (pipe_q << 1) | RD_LATENCY'(rd_en);
    end
  end

  // Sequencer with registered busy/done. DONE is entered either with done
  // already raised (after the last beat) or without (zero-length transfer),
  // in which case it spends one extra cycle raising it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      base_q      <= '0;
      num_q       <= '0;
      rd_issued_q <= '0;
      beat_cnt_q  <= '0;
    end else if (flush) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (rd_en) rd_issued_q <= rd_issued_q + 32'd1;
      if (hs)    beat_cnt_q  <= beat_cnt_q + 32'd1;
      unique case (state_q)
        StIdle: begin
          if (start_i && !abort_i) begin
            base_q      <= base_addr_i;
            num_q       <= num_words_i;
            rd_issued_q <= '0;
            beat_cnt_q  <= '0;
            busy_q      <= 1'b1;
            state_q     <= (num_words_i == 32'd0) ? StDone : StRead;
          end
        end
        StRead: begin
          if (rd_en && (rd_issued_q + 32'd1 == num_q)) state_q <= StDrain;
        end
        StDrain: begin
          if (hs && last_beat) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          if (!done_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            done_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  bram_rd_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (flush),
    .push_i  (push),
    .data_i  (bram_dout_i),
    .pop_i   (hs),
    .data_o  (m_axis_tdata_o),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: a behavioural BRAM whose contents
// are a function of the address, expected addresses/beats queued at start,
// and a negedge monitor that pops and compares.
module tb_bram_stream_reader;

  localparam int unsigned DW  = 256;
  localparam int unsigned AW  = 32;
  localparam int unsigned BPW = DW / 8;
  localparam int unsigned FD  = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [31:0]   num_words = '0;
  logic          busy, done, bram_en, tvalid, tlast;
  logic          tready = 1'b0;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_dout = '0;
  logic [DW-1:0] tdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_mode = 0;
  logic [31:0] seed = 32'h1234_5678;

  beat_t         exp_beats[$];
  logic [AW-1:0] exp_addrs[$];

  int en_cnt = 0, xfer_en = 0, beats_seen = 0, done_cnt = 0;
  int start_cyc = 0, first_en_cyc = -1, last_en_cyc = -1, first_tv_cyc = -1;
  int last_beat_cyc = -1, done_cyc = -1;
  logic          stalled = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  beat_t         mb;
  logic [AW-1:0] ma;

  bram_stream_reader u_dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .start_i         (start),
    .abort_i         (abort),
    .base_addr_i     (base_addr),
    .num_words_i     (num_words),
    .busy_o          (busy),
    .done_o          (done),
    .bram_addr_o     (bram_addr),
    .bram_en_o       (bram_en),
    .bram_dout_i     (bram_dout),
    .m_axis_tvalid_o (tvalid),
    .m_axis_tdata_o  (tdata),
    .m_axis_tlast_o  (tlast),
    .m_axis_tready_i (tready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int k = 0; k < int'(DW / 32); k++) begin
      w[k*32 +: 32] = (a * 32'h9E37_79B1) ^ (seed + k * 32'h0100_0193);
    end
    return w;
  endfunction

  // Single-cycle-latency BRAM.
  always @(posedge clk) if (bram_en) bram_dout <= word_at(bram_addr);

  // Consumer ready pattern.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       tready = 1'b1;
        1:       tready = ~tready;
        2:       tready = ($urandom_range(0, 3) != 0);
        default: tready = 1'b0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: address stream, beat stream, stall stability, credit bound, done.
  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (bram_en) begin
        en_cnt++;
        xfer_en++;
        if (first_en_cyc < 0) first_en_cyc = cyc;
        last_en_cyc = cyc;
        if (exp_addrs.size() == 0) begin
          chk("bram_en_unexpected", bram_en, 1'b0);
        end else begin
          ma = exp_addrs.pop_front();
          chk("bram_addr", bram_addr, ma);
        end
      end
      if (tvalid) begin
        if (first_tv_cyc < 0) first_tv_cyc = cyc;
        if (stalled) begin
          chk("stall_tdata", tdata, prev_data);
          chk("stall_tlast", tlast, prev_last);
        end
      end
      if (tvalid && tready) begin
        beats_seen++;
        if (tlast) last_beat_cyc = cyc;
        if (exp_beats.size() == 0) begin
          chk("beat_unexpected", tvalid, 1'b0);
        end else begin
          mb = exp_beats.pop_front();
          chk("beat_tdata", tdata, mb.data);
          chk("beat_tlast", tlast, mb.last);
        end
      end
      if (bram_en) chk("credit_bound", (xfer_en - beats_seen) <= int'(FD), 1'b1);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      stalled   = tvalid && !tready;
      prev_data = tdata;
      prev_last = tlast;
    end
  end

  task automatic do_start(input logic [AW-1:0] base, input logic [31:0] n);
    beat_t b;
    @(posedge clk); #1;
    seed = $urandom;
    for (int i = 0; i < int'(n); i++) begin
      exp_addrs.push_back(base + AW'(i) * AW'(BPW));
      b.data = word_at(base + AW'(i) * AW'(BPW));
      b.last = (i == int'(n) - 1);
      exp_beats.push_back(b);
    end
    first_en_cyc = -1; last_en_cyc = -1; first_tv_cyc = -1;
    last_beat_cyc = -1; done_cyc = -1; xfer_en = 0; beats_seen = 0;
    base_addr = base;
    num_words = n;
    start = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int prev);
    int t = 0;
    while (done_cnt == prev && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_done_count"}, done_cnt, prev + 1);
    chk({name, "_beats_left"}, exp_beats.size(), 0);
    chk({name, "_addrs_left"}, exp_addrs.size(), 0);
  endtask

  task automatic run_basic(input string name);
    int prev;
    rdy_mode = 0;
    @(posedge clk);
    prev = done_cnt;
    do_start(32'h100, 32'd4);
    @(negedge clk);
    chk({name, "_busy"}, busy, 1'b1);
    wait_done(name, prev);
    chk({name, "_first_en"}, first_en_cyc, start_cyc + 1);
    chk({name, "_en_span"}, last_en_cyc - first_en_cyc, 3);
    chk({name, "_first_tvalid"}, first_tv_cyc, start_cyc + 3);
    chk({name, "_beat_span"}, last_beat_cyc - first_tv_cyc, 3);
    chk({name, "_done_cycle"}, done_cyc, last_beat_cyc + 1);
  endtask

  initial begin
    int prev, en0, t;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_bram_en", bram_en, 1'b0);
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_bram_addr", bram_addr, '0);
    chk("rst_tdata", tdata, '0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic back-to-back transfer.
    run_basic("basic");

    // Alternating ready.
    rdy_mode = 1;
    prev = done_cnt;
    do_start($urandom, 32'd8);
    wait_done("toggle", prev);

    // Zero-length transfer.
    rdy_mode = 0;
    prev = done_cnt;
    en0 = en_cnt;
    do_start(32'h400, 32'd0);
    @(negedge clk);
    chk("zero_busy_c1", busy, 1'b1);
    chk("zero_done_c1", done, 1'b0);
    @(negedge clk);
    chk("zero_busy_c2", busy, 1'b0);
    chk("zero_done_c2", done, 1'b1);
    @(negedge clk);
    chk("zero_done_c3", done, 1'b0);
    chk("zero_no_en", en_cnt, en0);
    chk("zero_no_tvalid", first_tv_cyc < 0, 1'b1);
    chk("zero_done_count", done_cnt, prev + 1);

    // Abort after the fifth beat.
    prev = done_cnt;
    do_start(32'h1000, 32'd16);
    t = 0;
    while (beats_seen < 5 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reached_beat5", beats_seen >= 5, 1'b1);
    rdy_mode = 3;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_addrs.delete();
    exp_beats.delete();
    @(negedge clk);
    chk("abort_tvalid", tvalid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_bram_en", bram_en, 1'b0);
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_cnt, prev);
    rdy_mode = 0;
    prev = done_cnt;
    do_start(32'h800, 32'd6);
    wait_done("after_abort", prev);

    // Address wrap.
    prev = done_cnt;
    do_start(32'hFFFF_FFE0, 32'd2);
    wait_done("wrap", prev);

    // Randomized transfers with random backpressure.
    for (int r = 0; r < 8; r++) begin
      rdy_mode = 2;
      prev = done_cnt;
      do_start($urandom, $urandom_range(1, 24));
      wait_done("random", prev);
    end

    // Reset in the middle of a stalled transfer.
    rdy_mode = 3;
    prev = done_cnt;
    do_start(32'h200, 32'd8);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_bram_en", bram_en, 1'b0);
    chk("midrst_tvalid", tvalid, 1'b0);
    chk("midrst_tlast", tlast, 1'b0);
    chk("midrst_bram_addr", bram_addr, '0);
    chk("midrst_tdata", tdata, '0);
    exp_addrs.delete();
    exp_beats.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done_cnt, prev);
    run_basic("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
